// File: rtl/dmx_frame_sequencer.sv
// DMX512 frame generator: break, mark-after-break, start code, then NUM_CH channel bytes from RAM.
// tx is registered; each slot byte is prefetched during the previous slot's stop bits; start is ignored while busy.
module dmx_frame_sequencer #(
    parameter int NUM_CH     = 512,
    parameter int BREAK_BITS = 23,
    parameter int MAB_BITS   = 3
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       start,
    input  logic [7:0] ram_rd_data,
    output logic [8:0] ram_addr,
    output logic       ram_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        BREAK,
        MAB,
        START_BIT,
        DATA,
        STOP
    } state_t;

    localparam logic [4:0] BRK_LAST  = 5'(BREAK_BITS - 1);
    localparam logic [4:0] MAB_LAST  = 5'(MAB_BITS - 1);
    localparam logic [9:0] LAST_SLOT = 10'(NUM_CH);

    state_t     state_q;
    logic [9:0] slot_q;
    logic [4:0] bit_q;
    logic [7:0] hold_q;
    logic [7:0] shift_q;
    logic [8:0] addr_q;
    logic       tx_q;
    logic       busy_q;
    logic       done_q;
    logic       rd_q;

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            // RAM returns data the clock after the strobe
            if (rd_q) begin
                hold_q <= ram_rd_data;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (bit_en) begin
                        state_q <= BREAK;
                        tx_q    <= 1'b0;
                        bit_q   <= '0;
                    end
                end
                BREAK: begin
                    if (bit_en) begin
                        if (bit_q == BRK_LAST) begin
                            state_q <= MAB;
                            tx_q    <= 1'b1;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                end
                MAB: begin
                    if (bit_en) begin
                        if (bit_q == MAB_LAST) begin
                            state_q <= START_BIT;
                            tx_q    <= 1'b0;
                            bit_q   <= '0;
                            shift_q <= 8'h00;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                end
                START_BIT: begin
                    if (bit_en) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    if (bit_en) begin
                        if (bit_q == 5'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            bit_q   <= '0;
                            // slot s carries channel s-1, so fetch channel s for the next slot
                            if (slot_q != LAST_SLOT) begin
                                rd_q   <= 1'b1;
                                addr_q <= slot_q[8:0];
                            end
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_en) begin
                        if (bit_q == 5'd0) begin
                            bit_q <= 5'd1;
                        end else if (slot_q == LAST_SLOT) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            slot_q  <= '0;
                            bit_q   <= '0;
                        end else begin
                            state_q <= START_BIT;
                            tx_q    <= 1'b0;
                            slot_q  <= slot_q + 10'd1;
                            bit_q   <= '0;
                            shift_q <= hold_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign ram_rd     = rd_q;
    assign ram_addr   = addr_q;

endmodule
